openmips_test_monitor: RTL

//   Hardware-side end-of-test monitor for the OpenMIPS minimal SOPC. Snoops the CPU

---
 rtl/openmips_test_monitor.sv | 88 ++++++++
 1 files changed

// File: rtl/openmips_test_monitor.sv
// End-of-test monitor for the OpenMIPS SOPC: snoops write-back, keeps counters and a
// rotate-xor signature, and latches a PASS/FAIL/TIMEOUT verdict until reset.
module openmips_test_monitor #(
  parameter logic [4:0]  DONE_REG       = 5'd2,
  parameter logic [31:0] PASS_VAL       = 32'h0000_0001,
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wb_wreg,
  input  logic [4:0]  wb_wd,
  input  logic [31:0] wb_wdata,
  output logic        done,
  output logic        pass,
  output logic        fail,
  output logic        timeout,
  output logic [31:0] cycle_count,
  output logic [31:0] wb_count,
  output logic [31:0] signature,
  output logic [31:0] result
);

  typedef enum logic [1:0] {
    S_RUN     = 2'd0,
    S_PASS    = 2'd1,
    S_FAIL    = 2'd2,
    S_TIMEOUT = 2'd3
  } state_t;

  state_t      r_state;
  logic        r_done, r_pass, r_fail, r_timeout;
  logic [31:0] r_cycle, r_wbcnt, r_sig, r_result;

  logic        w_qual, w_mbox, w_last;
  logic [31:0] w_sig_next;

  // Writes to $0 never qualify, even with the enable set.
  assign w_qual     = wb_wreg && (wb_wd != 5'd0);
  assign w_mbox     = w_qual && (wb_wd == DONE_REG);
  assign w_last     = (r_cycle == TIMEOUT_CYCLES - 32'd1);
  assign w_sig_next = {r_sig[30:0], r_sig[31]} ^ wb_wdata ^ {27'd0, wb_wd};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_RUN;
      r_done    <= 1'b0;
      r_pass    <= 1'b0;
      r_fail    <= 1'b0;
      r_timeout <= 1'b0;
      r_cycle   <= 32'd0;
      r_wbcnt   <= 32'd0;
      r_sig     <= 32'd0;
      r_result  <= 32'd0;
    end else if (r_state == S_RUN) begin
      r_cycle <= r_cycle + 32'd1;
      if (w_qual) begin
        if (r_wbcnt != 32'hFFFF_FFFF) r_wbcnt <= r_wbcnt + 32'd1;
        r_sig <= w_sig_next;
      end
      // Mailbox takes priority over a timeout landing on the same edge.
      if (w_mbox) begin
        r_result <= wb_wdata;
        r_done   <= 1'b1;
        if (wb_wdata == PASS_VAL) begin
          r_state <= S_PASS;
          r_pass  <= 1'b1;
        end else begin
          r_state <= S_FAIL;
          r_fail  <= 1'b1;
        end
      end else if (w_last) begin
        r_state   <= S_TIMEOUT;
        r_done    <= 1'b1;
        r_timeout <= 1'b1;
      end
    end
  end

  assign done        = r_done;
  assign pass        = r_pass;
  assign fail        = r_fail;
  assign timeout     = r_timeout;
  assign cycle_count = r_cycle;
  assign wb_count    = r_wbcnt;
  assign signature   = r_sig;
  assign result      = r_result;

endmodule
